// File: rtl/stp_sr_ctrl.sv
// Handshake controller for a serial-to-parallel hash-word register: gathers NUM_WORDS words into a block.
// It holds the block until block_ack. The optional fill watchdog is built when STP_SR_CTRL_TIMEOUT_EN is defined.
module stp_sr_ctrl #(
    parameter int NUM_WORDS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        shift_enable,
    input  logic        abort,
    output logic        block_valid,
    input  logic        block_ack,
    output logic [7:0]  word_count,
    output logic [15:0] block_count,
    output logic        timeout_err
);

    if (NUM_WORDS < 1 || NUM_WORDS > 255) begin : g_badNumWords
        $error("stp_sr_ctrl: NUM_WORDS must be within 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
        $error("stp_sr_ctrl: TIMEOUT_CYCLES must be within 1..65535");
    end

    localparam logic [7:0] LastWord = 8'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wordCount_q, wordCount_d;
    logic [15:0] blockCount_q, blockCount_d;
    logic        accept;
    logic        wdFire;

    assign in_ready    = (state_q != FULL);
    assign block_valid = (state_q == FULL);
    assign accept      = in_valid & in_ready & ~abort;
    // The serial register must never see a shift while reset is held, even though in_ready reads 1.
    assign shift_enable = accept & n_rst;

    always_comb begin
        state_d      = state_q;
        wordCount_d  = wordCount_q;
        blockCount_d = blockCount_q;
        case (state_q)
            IDLE, FILL: begin
                if (wdFire || abort) begin
                    state_d     = IDLE;
                    wordCount_d = 8'd0;
                end else if (accept) begin
                    wordCount_d = wordCount_q + 8'd1;
                    state_d     = (wordCount_q + 8'd1 == LastWord) ? FULL : FILL;
                end
            end
            FULL: begin
                // An acknowledge wins over a simultaneous abort, so the block is counted as delivered.
                if (block_ack) begin
                    state_d      = IDLE;
                    wordCount_d  = 8'd0;
                    blockCount_d = blockCount_q + 16'd1;
                end else if (abort) begin
                    state_d     = IDLE;
                    wordCount_d = 8'd0;
                end
            end
            default: begin
                state_d     = IDLE;
                wordCount_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            wordCount_q  <= 8'd0;
            blockCount_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            wordCount_q  <= wordCount_d;
            blockCount_q <= blockCount_d;
        end
    end

    assign word_count  = wordCount_q;
    assign block_count = blockCount_q;

`ifdef STP_SR_CTRL_TIMEOUT_EN
    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdCount_q, wdCount_d;
    logic        timeoutErr_q;

    // Fires in the cycle whose edge would bring the idle count up to TIMEOUT_CYCLES.
    assign wdFire = (state_q == FILL) && !accept && (wdCount_q == WdLimit);

    always_comb begin
        wdCount_d = wdCount_q + 16'd1;
        if (state_d != FILL || accept) begin
            wdCount_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdCount_q    <= 16'd0;
            timeoutErr_q <= 1'b0;
        end else begin
            wdCount_q    <= wdCount_d;
            timeoutErr_q <= wdFire;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign wdFire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_stp_sr_ctrl.sv
// Directed testbench for stp_sr_ctrl. It uses NUM_WORDS=8 and TIMEOUT_CYCLES=16.
// The timeout checks follow STP_SR_CTRL_TIMEOUT_EN.
module tb_stp_sr_ctrl;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic        shift_enable;
    logic        abort;
    logic        block_valid;
    logic        block_ack;
    logic [7:0]  word_count;
    logic [15:0] block_count;
    logic        timeout_err;

    int compared;
    int mismatched;

    stp_sr_ctrl #(
        .NUM_WORDS      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_enable (shift_enable),
        .abort        (abort),
        .block_valid  (block_valid),
        .block_ack    (block_ack),
        .word_count   (word_count),
        .block_count  (block_count),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, and outputs are then sampled 1 ns later.
    task automatic applyStimulus(input logic v, input logic ab, input logic ack);
        @(negedge clk);
        in_valid  = v;
        abort     = ab;
        block_ack = ack;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        n_rst      = 1'b0;
        in_valid   = 1'b1;
        abort      = 1'b0;
        block_ack  = 1'b0;

        #12;
        checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("rst_block_valid", 16'(block_valid), 16'd0);
        checkOutput("rst_shift_enable", 16'(shift_enable), 16'd0);
        checkOutput("rst_word_count", 16'(word_count), 16'd0);
        checkOutput("rst_block_count", block_count, 16'd0);
        checkOutput("rst_timeout_err", 16'(timeout_err), 16'd0);

        @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b1;

        // Eight back-to-back accepts.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("fill_shift", 16'(shift_enable), 16'd1);
            checkOutput("fill_wc", 16'(word_count), 16'(i));
            checkOutput("fill_block_valid", 16'(block_valid), 16'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("full_block_valid", 16'(block_valid), 16'd1);
        checkOutput("full_wc", 16'(word_count), 16'd8);
        checkOutput("full_in_ready", 16'(in_ready), 16'd0);
        checkOutput("full_shift", 16'(shift_enable), 16'd0);

        // The stall continues while block_ack stays low.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("stall_shift", 16'(shift_enable), 16'd0);
            checkOutput("stall_block_valid", 16'(block_valid), 16'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ack_cycle_shift", 16'(shift_enable), 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_ack_block_count", block_count, 16'd1);
        checkOutput("post_ack_wc", 16'(word_count), 16'd0);
        checkOutput("stalled_word_shift", 16'(shift_enable), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("second_word_wc", 16'(word_count), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("third_word_wc", 16'(word_count), 16'd2);

        // Abort with three words held and in_valid high.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("abort_wc_before", 16'(word_count), 16'd3);
        checkOutput("abort_shift", 16'(shift_enable), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_wc_after", 16'(word_count), 16'd0);
        checkOutput("abort_in_ready", 16'(in_ready), 16'd1);

        // Block acknowledge in IDLE has no effect.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_ack_ignored", block_count, 16'd1);

        // A fresh block after the abort, then abort and ack together.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("refill_wc", 16'(word_count), 16'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("refill_block_valid", 16'(block_valid), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ack_wins_block_count", block_count, 16'd2);
        checkOutput("ack_wins_block_valid", 16'(block_valid), 16'd0);

        // A full block, then abort alone.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop_block_valid_before", 16'(block_valid), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drop_block_count", block_count, 16'd2);
        checkOutput("drop_wc", 16'(word_count), 16'd0);
        checkOutput("drop_block_valid", 16'(block_valid), 16'd0);

        // Two words, then a long idle gap inside the partial block.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("gap_wc", 16'(word_count), 16'd2);
            checkOutput("gap_timeout_err", 16'(timeout_err), 16'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef STP_SR_CTRL_TIMEOUT_EN
        checkOutput("timeout_pulse", 16'(timeout_err), 16'd1);
        checkOutput("timeout_wc", 16'(word_count), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("timeout_pulse_end", 16'(timeout_err), 16'd0);
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("hold_wc", 16'(word_count), 16'd2);
            checkOutput("hold_timeout_err", 16'(timeout_err), 16'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("hold_abort_wc", 16'(word_count), 16'd0);
`endif

        // Reset asserted mid-block acts without a clock edge.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset_wc", 16'(word_count), 16'd5);
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("async_rst_wc", 16'(word_count), 16'd0);
        checkOutput("async_rst_block_count", block_count, 16'd0);
        checkOutput("async_rst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("async_rst_shift", 16'(shift_enable), 16'd0);
        checkOutput("async_rst_block_valid", 16'(block_valid), 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b1;

        // Block counter wrap from 0xFFFF.
        applyStimulus(1'b0, 1'b0, 1'b0);
        force dut.blockCount_q = 16'hFFFF;
        #1;
        release dut.blockCount_q;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("post_rst_wc", 16'(word_count), 16'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("wrap_block_valid", 16'(block_valid), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrap_block_count", block_count, 16'h0000);
        checkOutput("wrap_wc", 16'(word_count), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stp_sr_ctrl.md
STP_SR_CTRL -- requirements
Module: stp_sr_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 8, words per block; SHALL match the NUM_WORDS of the attached shift register; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, idle-cycle limit inside a partial block; legal range 1..65535.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream hash word present on the shared serial data bus.
REQ-006 in_ready  output  1  controller can accept a word this cycle.
REQ-007 shift_enable  output  1  drives shift_enable of the serial-to-parallel register.
REQ-008 abort  input  1  synchronous discard of the block being assembled.
REQ-009 block_valid  output  1  parallel register holds NUM_WORDS fresh words.
REQ-010 block_ack  input  1  downstream consumer has taken the block.
REQ-011 word_count  output  8  words accepted into the current block.
REQ-012 block_count  output  16  blocks delivered since reset; wraps 0xFFFF->0x0000.
REQ-013 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 FSM states: IDLE, FILL, FULL.
REQ-015 Outputs decode combinationally from registered state: in_ready=1 in IDLE/FILL, 0 in FULL; block_valid=1 only in FULL.
REQ-016 Accept = in_valid & in_ready & !abort.
REQ-017 shift_enable = accept; same cycle, no register stage; 0 in every other cycle so the register holds.
REQ-018 Each accept increments word_count by 1.
REQ-019 IDLE->FILL on an accept that leaves word_count < NUM_WORDS.
REQ-020 An accept that makes word_count == NUM_WORDS goes to FULL on the same edge, from IDLE or FILL.
REQ-021 Latency: block_valid rises in the cycle after the NUM_WORDS-th shift edge, coincident with the updated parallel output.
REQ-022 NUM_WORDS=1: the IDLE accept goes directly to FULL.
REQ-023 FULL holds until block_ack=1. Next edge: IDLE, word_count=0, block_count+1.
REQ-024 block_ack outside FULL SHALL be ignored.
REQ-025 abort in IDLE/FILL: next edge IDLE, word_count=0. No shift that cycle, even with in_valid=1.
REQ-026 abort in FULL without block_ack: block dropped. Next edge IDLE, word_count=0, block_count unchanged.
REQ-027 abort and block_ack together in FULL: ack wins, block counted.
REQ-028 in_valid in FULL is stalled (in_ready=0); the word is not lost and is accepted after the return to IDLE.

Reset
REQ-029 n_rst low SHALL asynchronously force: state IDLE, word_count=0, block_count=0, timeout_err=0, watchdog counter 0.
REQ-030 Reset output values: in_ready=1, block_valid=0, shift_enable=0 (in_valid is gated during reset).
REQ-031 Reset asserted mid-block discards the partial block; the first post-reset block starts at word_count=0.

Configuration
REQ-032 Macro STP_SR_CTRL_TIMEOUT_EN.
REQ-033 Defined: a 16-bit watchdog counts FILL cycles without an accept.
- Watchdog clears on an accept or on leaving FILL.
- On reaching TIMEOUT_CYCLES: next edge IDLE, word_count=0, timeout_err=1 for exactly one cycle.
- abort in the same cycle: same result, timeout_err still pulses.
REQ-034 Undefined: no watchdog logic; timeout_err tied 0; the port SHALL still exist.

Verification
REQ-035 Reset, then 8 back-to-back accepts -> shift_enable high 8 cycles; block_valid=1 on cycle 9; word_count=8; in_ready=0.
REQ-036 Block held with block_ack=0 for 20 cycles, in_valid=1 throughout -> shift_enable stays 0, block_valid stays 1; block_ack pulse -> IDLE, block_count=1, the stalled word accepted next cycle.
REQ-037 3 words, then abort with in_valid=1 -> no shift in the abort cycle, word_count=0; a fresh 8-word block then completes normally.
REQ-038 Full block, abort and block_ack together -> block_count increments. Repeat with abort alone -> block_count unchanged.
REQ-039 With STP_SR_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 words, then in_valid=0 for 16 cycles -> one timeout_err pulse, word_count=0. Without the macro -> FILL held indefinitely, timeout_err=0.
REQ-040 n_rst pulsed low mid-block (word_count=5) -> all outputs return to reset values immediately, without waiting for a clock edge; block_count preset to 0xFFFF then one block -> 0x0000.
